// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debounce filter.
package debounce_pkg;

    localparam int unsigned DefaultCntW       = 4;
    localparam int unsigned DefaultSyncStages = 2;

    // A threshold of zero behaves like one: flip on the first mismatching sample.
    function automatic logic [31:0] eff_thresh(input logic [31:0] thresh);
        return (thresh == 32'd0) ? 32'd1 : thresh;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: input synchroniser, stability counter and registered
// rise/fall event pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_W       = DefaultCntW,
    parameter int unsigned SYNC_STAGES = DefaultSyncStages,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] thresh,
    input  logic             sig_in,
    output logic             sig_out,
    output logic             rise,
    output logic             fall
);

    logic             sample;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [31:0]      thr_eff;
    logic [31:0]      cnt_inc;

    if (SYNC_STAGES > 0) begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                sync_q <= {SYNC_STAGES{RESET_VAL}};
            end else if (enable) begin
                sync_q[0] <= sig_in;
                for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign sample = sync_q[SYNC_STAGES-1];
    end else begin : g_bypass
        assign sample = sig_in;
    end

    assign thr_eff = eff_thresh(32'(thresh));
    assign cnt_inc = 32'(cnt_q) + 32'd1;

    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (enable) begin
            if (sample == out_q) begin
                cnt_d = '0;
            end else if (cnt_inc < thr_eff) begin
                cnt_d = CNT_W'(cnt_inc);
            end else begin
                // Threshold is compared live, so lowering it mid-count flips here.
                out_d  = sample;
                cnt_d  = '0;
                rise_d = sample;
                fall_d = ~sample;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            out_q  <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sig_out = out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;

endmodule

// File: rtl/debounce_filter_multi.sv
// Multi-channel debounce filter: fans shared controls out to independent
// per-channel filters and gathers their outputs.
module debounce_filter_multi
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_W       = DefaultCntW,
    parameter int unsigned SYNC_STAGES = DefaultSyncStages,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [CNT_W-1:0]    thresh,
    input  logic [CHANNELS-1:0] sig_in,
    output logic [CHANNELS-1:0] sig_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_chan
        debounce_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_VAL   (RESET_VAL)
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .enable  (enable),
            .thresh  (thresh),
            .sig_in  (sig_in[i]),
            .sig_out (sig_out[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

endmodule
